flash2ram_loader: RTL and testbench

//   Boot-time copier: reads a program image from flash through the flash_driver read

---
 rtl/flash2ram_loader.sv | 145 ++++++++++++++
 tb/tb_flash2ram_loader.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/flash2ram_loader.sv
// Boot-time copier: assembles 32-bit words from pairs of 16-bit flash reads
// (low halfword first) and writes them to RAM, holding busy until the image is loaded.
module flash2ram_loader #(
  parameter int FLASH_AW   = 22,
  parameter int RAM_AW     = 20,
  parameter int FLASH_BASE = 0,
  parameter int RAM_BASE   = 0,
  parameter int LOAD_WORDS = 1024
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  output logic [FLASH_AW-1:0] fl_addr,
  output logic                fl_rd_en,
  input  logic [15:0]         fl_data,
  input  logic                fl_rd_done,
  output logic [RAM_AW-1:0]   ram_addr,
  output logic [31:0]         ram_wdata,
  output logic                ram_we,
  input  logic                ram_ack,
  output logic                busy,
  output logic                done,
  output logic [RAM_AW:0]     word_cnt
);

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] RD_LO  = 3'd1;
  localparam logic [2:0] GAP_LO = 3'd2;
  localparam logic [2:0] RD_HI  = 3'd3;
  localparam logic [2:0] GAP_HI = 3'd4;
  localparam logic [2:0] WR     = 3'd5;
  localparam logic [2:0] DONE   = 3'd6;

  localparam logic [RAM_AW:0]     LAST_CNT = (RAM_AW+1)'(LOAD_WORDS);
  localparam logic [FLASH_AW-1:0] FL_BASE  = FLASH_AW'(FLASH_BASE);
  localparam logic [RAM_AW-1:0]   RM_BASE  = RAM_AW'(RAM_BASE);

  logic [2:0]          state_q, state_d;
  logic [RAM_AW:0]     word_cnt_q, word_cnt_d;
  logic [15:0]         lo_q, lo_d;
  logic [15:0]         hi_q, hi_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                fl_rd_en_q, fl_rd_en_d;
  logic [FLASH_AW-1:0] fl_addr_q, fl_addr_d;
  logic                ram_we_q, ram_we_d;
  logic [RAM_AW-1:0]   ram_addr_q, ram_addr_d;
  logic [31:0]         ram_wdata_q, ram_wdata_d;
  logic [FLASH_AW-1:0] fl_off;

  always_comb begin
    state_d    = state_q;
    word_cnt_d = word_cnt_q;
    lo_d       = lo_q;
    hi_d       = hi_q;
    busy_d     = busy_q;
    done_d     = done_q;
    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d    = RD_LO;
          word_cnt_d = '0;
          busy_d     = 1'b1;
          done_d     = 1'b0;
        end
      end
      RD_LO: begin
        if (fl_rd_done) begin
          lo_d    = fl_data;
          state_d = GAP_LO;
        end
      end
      GAP_LO: state_d = RD_HI;
      RD_HI: begin
        if (fl_rd_done) begin
          hi_d    = fl_data;
          state_d = GAP_HI;
        end
      end
      GAP_HI: state_d = WR;
      WR: begin
        if (ram_ack) begin
          word_cnt_d = word_cnt_q + 1'b1;
          if (word_cnt_d == LAST_CNT) begin
            state_d = DONE;
            busy_d  = 1'b0;
            done_d  = 1'b1;
          end else begin
            state_d = RD_LO;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Request outputs are registered copies of what the next state wants, so they
  // change on the same edge as the state and hold steady while a handshake waits.
  always_comb begin
    fl_rd_en_d  = (state_d == RD_LO) || (state_d == RD_HI);
    ram_we_d    = (state_d == WR);
    fl_off      = FLASH_AW'({word_cnt_d, state_d == RD_HI});
    fl_addr_d   = fl_rd_en_d ? (FL_BASE + fl_off) : fl_addr_q;
    ram_addr_d  = ram_we_d ? (RM_BASE + word_cnt_d[RAM_AW-1:0]) : ram_addr_q;
    ram_wdata_d = ram_we_d ? {hi_d, lo_d} : ram_wdata_q;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      word_cnt_q  <= '0;
      lo_q        <= '0;
      hi_q        <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      fl_rd_en_q  <= 1'b0;
      fl_addr_q   <= '0;
      ram_we_q    <= 1'b0;
      ram_addr_q  <= '0;
      ram_wdata_q <= '0;
    end else begin
      state_q     <= state_d;
      word_cnt_q  <= word_cnt_d;
      lo_q        <= lo_d;
      hi_q        <= hi_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      fl_rd_en_q  <= fl_rd_en_d;
      fl_addr_q   <= fl_addr_d;
      ram_we_q    <= ram_we_d;
      ram_addr_q  <= ram_addr_d;
      ram_wdata_q <= ram_wdata_d;
    end
  end

  assign fl_addr   = fl_addr_q;
  assign fl_rd_en  = fl_rd_en_q;
  assign ram_addr  = ram_addr_q;
  assign ram_wdata = ram_wdata_q;
  assign ram_we    = ram_we_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign word_cnt  = word_cnt_q;

endmodule

// File: tb/tb_flash2ram_loader.sv
// Bench for flash2ram_loader: flash returns h[n]=n with programmable latency, RAM acks
// with programmable latency; expected RAM writes are queued at start and popped on ack.
module tb_flash2ram_loader;
  localparam int N = 4;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, start, start2;
  logic [21:0] fl_addr;
  logic        fl_rd_en, fl_rd_done;
  logic [15:0] fl_data;
  logic [19:0] ram_addr;
  logic [31:0] ram_wdata;
  logic        ram_we, ram_ack, busy, done;
  logic [20:0] word_cnt;

  logic [21:0] fl_addr2;
  logic        fl_rd_en2, fl_rd_done2;
  logic [15:0] fl_data2;
  logic [3:0]  ram_addr2;
  logic [31:0] ram_wdata2;
  logic        ram_we2, ram_ack2, busy2, done2;
  logic [4:0]  word_cnt2;

  flash2ram_loader #(.LOAD_WORDS(N)) dut (
    .clk(clk), .rst(rst), .start(start),
    .fl_addr(fl_addr), .fl_rd_en(fl_rd_en), .fl_data(fl_data), .fl_rd_done(fl_rd_done),
    .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_we(ram_we), .ram_ack(ram_ack),
    .busy(busy), .done(done), .word_cnt(word_cnt)
  );

  flash2ram_loader #(.RAM_AW(4), .RAM_BASE(14), .LOAD_WORDS(4)) dut2 (
    .clk(clk), .rst(rst), .start(start2),
    .fl_addr(fl_addr2), .fl_rd_en(fl_rd_en2), .fl_data(fl_data2), .fl_rd_done(fl_rd_done2),
    .ram_addr(ram_addr2), .ram_wdata(ram_wdata2), .ram_we(ram_we2), .ram_ack(ram_ack2),
    .busy(busy2), .done(done2), .word_cnt(word_cnt2)
  );

  // zero-wait flash and RAM for the wrap instance
  assign fl_rd_done2 = fl_rd_en2;
  assign fl_data2    = fl_addr2[15:0];
  assign ram_ack2    = ram_we2;

  typedef struct {
    logic [19:0] a;
    logic [31:0] d;
    logic [20:0] c;
  } exp_t;
  exp_t sb[$];

  int checks = 0;
  int failures = 0;
  int fl_delay = 0, ram_delay = 0, fl_cnt = 0, ram_cnt = 0;
  bit inject = 1'b0;

  // flash/RAM responders for the main instance
  initial begin
    fl_rd_done = 1'b0; fl_data = '0; ram_ack = 1'b0;
    forever begin
      @(posedge clk); #1;
      fl_rd_done = 1'b0;
      ram_ack    = 1'b0;
      if (fl_rd_en) begin
        if (fl_cnt >= fl_delay) begin
          fl_rd_done = 1'b1; fl_data = fl_addr[15:0]; fl_cnt = 0;
        end else fl_cnt++;
      end else fl_cnt = 0;
      if (ram_we) begin
        if (ram_cnt >= ram_delay) begin
          ram_ack = 1'b1; ram_cnt = 0;
        end else ram_cnt++;
        if (inject) begin
          fl_rd_done = 1'b1; fl_data = 16'hDEAD;
        end
      end else ram_cnt = 0;
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  task automatic run_copy(input int fd, input int rd, input bit inj, output int cyc);
    exp_t e;
    logic pw, pr, pack, pdone, wr_seen;
    logic [19:0] pa;
    logic [31:0] pd;
    logic [21:0] pfa;
    int gap;
    fl_delay = fd; ram_delay = rd; inject = 1'b0;
    for (int i = 0; i < N; i++) begin
      e.a = 20'(i); e.d = {16'(2*i+1), 16'(2*i)}; e.c = 21'(i);
      sb.push_back(e);
    end
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0; cyc = 1;
    checks++;
    if (busy !== 1'b1 || done !== 1'b0 || word_cnt !== 21'd0 || fl_rd_en !== 1'b1 || fl_addr !== 22'd0) begin
      failures++;
      $display("FAIL start_accept busy=%b done=%b word_cnt=%0d fl_rd_en=%b fl_addr=%0d required 1 0 0 1 0",
               busy, done, word_cnt, fl_rd_en, fl_addr);
    end
    inject = inj;
    pw = 0; pr = 0; pack = 0; pdone = 0; wr_seen = 1; gap = 0; pa = '0; pd = '0; pfa = '0;
    while (done !== 1'b1 && cyc < 2000) begin
      start = inj && (cyc == 7 || cyc == 23);
      checks++;
      if (fl_rd_en && ram_we) begin
        failures++; $display("FAIL rd_we_exclusive fl_rd_en=%b ram_we=%b at cyc %0d", fl_rd_en, ram_we, cyc);
      end
      if (pw && !pack) begin
        checks++;
        if (ram_we !== 1'b1 || ram_addr !== pa || ram_wdata !== pd) begin
          failures++; $display("FAIL ram_hold we=%b addr=%h data=%h required 1 %h %h", ram_we, ram_addr, ram_wdata, pa, pd);
        end
      end
      if (pw && pack) begin
        checks++;
        if (ram_we !== 1'b0) begin
          failures++; $display("FAIL we_drop ram_we=%b required 0 after ack", ram_we);
        end
      end
      if (pr && !pdone) begin
        checks++;
        if (fl_rd_en !== 1'b1 || fl_addr !== pfa) begin
          failures++; $display("FAIL rd_hold rd_en=%b addr=%h required 1 %h", fl_rd_en, fl_addr, pfa);
        end
      end
      if (fl_rd_en && !pr) begin
        if (!wr_seen) begin
          checks++;
          if (gap !== 1) begin
            failures++; $display("FAIL rd_gap gap=%0d required 1", gap);
          end
        end
        gap = 0; wr_seen = 0;
      end else if (!fl_rd_en) begin
        gap++;
        if (ram_we) wr_seen = 1;
      end
      if (ram_we && ram_ack) begin
        checks++;
        if (sb.size() == 0) begin
          failures++; $display("FAIL sb_underflow extra write addr=%h data=%h", ram_addr, ram_wdata);
        end else begin
          e = sb.pop_front();
          if (ram_addr !== e.a || ram_wdata !== e.d || word_cnt !== e.c) begin
            failures++;
            $display("FAIL ram_write addr=%h data=%h cnt=%0d required %h %h %0d",
                     ram_addr, ram_wdata, word_cnt, e.a, e.d, e.c);
          end
        end
      end
      pw = ram_we; pa = ram_addr; pd = ram_wdata; pack = ram_ack;
      pr = fl_rd_en; pfa = fl_addr; pdone = fl_rd_done;
      @(negedge clk); cyc++;
    end
    start = 1'b0; inject = 1'b0;
    checks++;
    if (done !== 1'b1 || busy !== 1'b0 || word_cnt !== 21'(N) || fl_rd_en !== 1'b0 || ram_we !== 1'b0) begin
      failures++;
      $display("FAIL copy_end done=%b busy=%b word_cnt=%0d rd_en=%b we=%b required 1 0 %0d 0 0",
               done, busy, word_cnt, fl_rd_en, ram_we, N);
    end
    checks++;
    if (sb.size() != 0) begin
      failures++; $display("FAIL sb_leftover remaining=%0d required 0", sb.size());
    end
    sb.delete();
  endtask

  task automatic test_reset();
    rst = 1'b0; start = 1'b0; start2 = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if ({fl_addr, fl_rd_en, ram_addr, ram_wdata, ram_we, busy, done, word_cnt} !== '0) begin
      failures++; $display("FAIL reset_outputs busy=%b done=%b rd_en=%b we=%b required all 0", busy, done, fl_rd_en, ram_we);
    end
    rst = 1'b1;
    fl_delay = 0; ram_delay = 0;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    repeat (7) @(negedge clk);
    rst = 1'b0; #1;
    checks++;
    if ({fl_addr, fl_rd_en, ram_addr, ram_wdata, ram_we, busy, done, word_cnt} !== '0) begin
      failures++;
      $display("FAIL midrun_reset addr=%h rd_en=%b raddr=%h wdata=%h we=%b busy=%b done=%b cnt=%0d required all 0",
               fl_addr, fl_rd_en, ram_addr, ram_wdata, ram_we, busy, done, word_cnt);
    end
    @(negedge clk); rst = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if ({fl_addr, fl_rd_en, ram_addr, ram_wdata, ram_we, busy, done, word_cnt} !== '0) begin
      failures++; $display("FAIL idle_after_reset busy=%b rd_en=%b we=%b cnt=%0d required all 0", busy, fl_rd_en, ram_we, word_cnt);
    end
  endtask

  task automatic test_basic();
    int cyc;
    run_copy(0, 0, 1'b0, cyc);
    checks++;
    if (cyc !== 5*N+1) begin
      failures++; $display("FAIL basic_latency cycles=%0d required %0d", cyc, 5*N+1);
    end
  endtask

  task automatic test_wait_states();
    int cyc;
    run_copy(7, 3, 1'b0, cyc);
    checks++;
    if (cyc !== (2*8 + 2 + 4)*N + 1) begin
      failures++; $display("FAIL wait_latency cycles=%0d required %0d", cyc, (2*8+2+4)*N+1);
    end
  endtask

  task automatic test_spurious();
    int cyc;
    run_copy(1, 1, 1'b1, cyc);
    checks++;
    if (cyc !== (4 + 2 + 2)*N + 1) begin
      failures++; $display("FAIL spurious_latency cycles=%0d required %0d", cyc, 8*N+1);
    end
  endtask

  task automatic test_back_to_back();
    int c1, c2;
    run_copy(0, 0, 1'b0, c1);
    run_copy(0, 0, 1'b0, c2);
    checks++;
    if (c2 !== c1 || c2 !== 5*N+1) begin
      failures++; $display("FAIL restart_latency first=%0d second=%0d required %0d", c1, c2, 5*N+1);
    end
  endtask

  task automatic test_ram_wrap();
    exp_t e;
    int cyc;
    logic [3:0] wrap_addr [4];
    wrap_addr[0] = 4'd14; wrap_addr[1] = 4'd15; wrap_addr[2] = 4'd0; wrap_addr[3] = 4'd1;
    for (int i = 0; i < 4; i++) begin
      e.a = {16'd0, wrap_addr[i]}; e.d = {16'(2*i+1), 16'(2*i)}; e.c = 21'(i);
      sb.push_back(e);
    end
    @(negedge clk); start2 = 1'b1;
    @(negedge clk); start2 = 1'b0; cyc = 1;
    while (done2 !== 1'b1 && cyc < 200) begin
      if (ram_we2 && ram_ack2) begin
        checks++;
        if (sb.size() == 0) begin
          failures++; $display("FAIL wrap_underflow addr=%0d", ram_addr2);
        end else begin
          e = sb.pop_front();
          if ({16'd0, ram_addr2} !== e.a || ram_wdata2 !== e.d || {16'd0, word_cnt2} !== e.c) begin
            failures++;
            $display("FAIL wrap_write addr=%0d data=%h cnt=%0d required %0d %h %0d",
                     ram_addr2, ram_wdata2, word_cnt2, e.a, e.d, e.c);
          end
        end
      end
      @(negedge clk); cyc++;
    end
    checks++;
    if (done2 !== 1'b1 || cyc !== 21 || sb.size() != 0 || word_cnt2 !== 5'd4) begin
      failures++;
      $display("FAIL wrap_end done=%b cycles=%0d left=%0d cnt=%0d required 1 21 0 4", done2, cyc, sb.size(), word_cnt2);
    end
    sb.delete();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_wait_states();
    test_spurious();
    test_back_to_back();
    test_ram_wrap();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
